nibble_serial_add_ctrl: RTL and testbench

Sequencer that performs WIDTH-bit add/subtract by time-multiplexing a single 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first. It latches operands via a valid/ready request handshake and runs the nibble loop with a registered inter-nibble carry. It returns sum, carry-out and signed overflow via a valid/ready response handshake. It trades latency for area in the arithmetic datapath.

---
 rtl/nibble_serial_add_ctrl_pkg.sv | 7 +
 rtl/nibble_serial_add_ctrl_add4.sv | 18 +
 rtl/nibble_serial_add_ctrl.sv | 105 ++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// nibble_serial_add_ctrl_pkg: shared state encoding and slice width for the nibble-serial adder.
package nibble_serial_add_ctrl_pkg;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam int NIBBLE_W = 4;
endpackage

// File: rtl/nibble_serial_add_ctrl_add4.sv
// nibble_add4: combinational 4-bit ripple-carry adder built from full-adder cells.
module nibble_add4
   import nibble_serial_add_ctrl_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a_i,
   input  logic [NIBBLE_W-1:0] b_i,
   input  logic                ci_i,
   output logic [NIBBLE_W-1:0] sum_o,
   output logic                co_o
);
   logic [NIBBLE_W:0] c;
   assign c[0] = ci_i;
   for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
      assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
   end
   assign co_o = c[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: WIDTH-bit add/subtract sequenced through one 4-bit adder slice,
// LSB nibble first, with valid/ready request and response handshakes.
module nibble_serial_add_ctrl
   import nibble_serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   input  logic             sub_i,
   output logic             busy_o,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o
);
   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int CW = $clog2(NIBBLES);

   logic [1:0]          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic                carry_q, carry_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
   logic [NIBBLE_W-1:0] s4;
   logic                co4;

   nibble_add4 u_add4 (
      .a_i   (a_q[NIBBLE_W-1:0]),
      .b_i   (b_q[NIBBLE_W-1:0]),
      .ci_i  (carry_q),
      .sum_o (s4),
      .co_o  (co4)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      ovf_d   = ovf_q;
      if (state_q == S_IDLE && req_valid_i) begin
         state_d = S_BUSY;
         cnt_d   = '0;
         a_d     = a_i;
         b_d     = sub_i ? ~b_i : b_i;
         carry_d = sub_i ? 1'b1 : cin_i;
         a_msb_d = a_i[WIDTH-1];
         b_msb_d = sub_i ? ~b_i[WIDTH-1] : b_i[WIDTH-1];
      end else if (state_q == S_BUSY) begin
         sum_d   = {s4, sum_q[WIDTH-1:NIBBLE_W]};
         a_d     = a_q >> NIBBLE_W;
         b_d     = b_q >> NIBBLE_W;
         carry_d = co4;
         cnt_d   = cnt_q + CW'(1);
         if (cnt_q == CW'(NIBBLES - 1)) begin
            state_d = S_DONE;
            // s4 is the top nibble here, so s4 MSB is the result sign bit
            ovf_d   = (a_msb_q == b_msb_q) && (s4[NIBBLE_W-1] != a_msb_q);
         end
      end else if (state_q == S_DONE && res_ready_i) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         ovf_q   <= ovf_d;
      end
   end

   assign req_ready_o = (state_q == S_IDLE);
   assign busy_o      = (state_q == S_BUSY);
   assign res_valid_o = (state_q == S_DONE);
   assign sum_o       = sum_q;
   assign cout_o      = carry_q;
   assign ovf_o       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed self-checking bench for the nibble-serial adder.
module tb_nibble_serial_add_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready;
   logic [15:0] a = '0, b = '0;
   logic        cin = 1'b0, sub = 1'b0;
   logic        busy, res_valid, res_ready = 1'b0;
   logic [15:0] sum;
   logic        cout, ovf;
   int          n_assert = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   nibble_serial_add_ctrl #(.WIDTH(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .a_i         (a),
      .b_i         (b),
      .cin_i       (cin),
      .sub_i       (sub),
      .busy_o      (busy),
      .res_valid_o (res_valid),
      .res_ready_i (res_ready),
      .sum_o       (sum),
      .cout_o      (cout),
      .ovf_o       (ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts);
      @(negedge clk);
      a = ta; b = tb; cin = tc; sub = ts; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1; sub = 1'b1;
      chk("busy_after_accept", busy, 1);
      chk("req_ready_busy", req_ready, 0);
   endtask

   task automatic wait_done(input string tag);
      repeat (3) begin
         @(negedge clk);
         chk({tag, "_early_valid"}, res_valid, 0);
      end
      @(negedge clk);
      chk({tag, "_res_valid"}, res_valid, 1);
   endtask

   task automatic result(input string tag, input logic [15:0] s, input logic c, input logic o);
      chk({tag, "_sum"}, sum, s);
      chk({tag, "_cout"}, cout, c);
      chk({tag, "_ovf"}, ovf, o);
   endtask

   task automatic respond(input string tag);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk({tag, "_valid_drop"}, res_valid, 0);
      chk({tag, "_idle_ready"}, req_ready, 1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      result("rst", 16'h0000, 1'b0, 1'b0);

      start(16'h1234, 16'h0FFF, 1'b0, 1'b0);
      wait_done("add");
      result("add", 16'h2233, 1'b0, 1'b0);
      respond("add");

      start(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_done("carry");
      result("carry", 16'h0000, 1'b1, 1'b0);
      respond("carry");

      start(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      wait_done("povf");
      result("povf", 16'h8000, 1'b0, 1'b1);
      respond("povf");

      start(16'h0005, 16'h0007, 1'b1, 1'b1);
      wait_done("sub");
      result("sub", 16'hFFFE, 1'b0, 1'b0);
      respond("sub");

      start(16'h8000, 16'h0001, 1'b0, 1'b1);
      wait_done("subovf");
      result("subovf", 16'h7FFF, 1'b1, 1'b1);
      respond("subovf");

      start(16'h0003, 16'h0004, 1'b0, 1'b0);
      wait_done("bp");
      a = 16'h0010; b = 16'h0020; cin = 1'b0; sub = 1'b0; req_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         result("bp_hold", 16'h0007, 1'b0, 1'b0);
         chk("bp_res_valid", res_valid, 1);
         chk("bp_req_ready", req_ready, 0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("bp_idle_ready", req_ready, 1);
      chk("bp_no_accept", busy, 0);
      @(negedge clk);
      req_valid = 1'b0;
      chk("bp_pending_accept", busy, 1);
      wait_done("bp2");
      result("bp2", 16'h0030, 1'b0, 1'b0);
      respond("bp2");

      start(16'h1111, 16'h2222, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req_ready", req_ready, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_res_valid", res_valid, 0);
      result("mid_rst", 16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", req_ready, 1);
      start(16'h0001, 16'h0001, 1'b0, 1'b0);
      wait_done("fresh");
      result("fresh", 16'h0002, 1'b0, 1'b0);
      respond("fresh");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
